// File: rtl/char_line_fetcher.sv
// char_line_fetcher: fetches COLS character codes and their glyph rows, serialises pixels MSB-first
module char_line_fetcher #(
  parameter int COLS   = 80,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_start,
  input  logic [3:0]        row,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cursor_en,
  input  logic [7:0]        cursor_col,
  output logic              vram_re,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [7:0]        vram_data,
  output logic [11:0]       rom_addr,
  input  logic [7:0]        rom_data,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              busy,
  output logic              line_done
);

  typedef enum logic [1:0] {IDLE, PRIME, SHIFT} state_t;

  localparam logic [7:0] LAST = 8'(COLS - 1);

  state_t      state, state_nxt;
  logic [2:0]  phase;
  logic [7:0]  col;
  logic [3:0]  row_q;
  logic        cur_en;
  logic [7:0]  cur_col;
  logic [7:0]  shift;
  logic [7:0]  hold;
  logic        last;
  logic [8:0]  glyph_col;
  logic        hit;
  logic [7:0]  glyph;

  assign last      = col == LAST;
  // PRIME fetches column 0; during SHIFT the prefetch is always for the next column
  assign glyph_col = {1'b0, col} + {8'd0, state == SHIFT};
  assign hit       = cur_en && ({1'b0, cur_col} == glyph_col);
  assign glyph     = rom_data ^ {8{hit}};
  assign pixel     = shift[7];

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state: PRIME lasts three edges, SHIFT ends after the last column's eighth pixel
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE  && line_start)                ? PRIME :
                (state == PRIME && phase == 3'd2)             ? SHIFT :
                (state == SHIFT && phase == 3'd7 && last)     ? IDLE  : state;
  end

  // datapath: VRAM/ROM sequencing, hold/shift registers and line status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram_re     <= 1'b0;
      vram_addr   <= '0;
      rom_addr    <= '0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      line_done   <= 1'b0;
      phase       <= '0;
      col         <= '0;
      row_q       <= '0;
      cur_en      <= 1'b0;
      cur_col     <= '0;
      shift       <= '0;
      hold        <= '0;
    end else begin
      vram_re   <= 1'b0;
      line_done <= 1'b0;
      case (state)
        IDLE: if (line_start) begin
          row_q     <= row;
          cur_en    <= cursor_en;
          cur_col   <= cursor_col;
          vram_addr <= base_addr;
          vram_re   <= 1'b1;
          busy      <= 1'b1;
          col       <= '0;
          phase     <= '0;
        end
        PRIME: begin
          phase <= phase + 3'd1;
          if (phase == 3'd0) rom_addr <= {vram_data, row_q};
          if (phase == 3'd1) hold <= glyph;
          if (phase == 3'd2) begin
            shift       <= hold;
            pixel_valid <= 1'b1;
            phase       <= '0;
          end
        end
        SHIFT: begin
          shift <= shift << 1;
          phase <= phase + 3'd1;
          if (phase == 3'd0 && !last) begin
            vram_re   <= 1'b1;
            vram_addr <= vram_addr + 1'b1;
          end
          if (phase == 3'd1 && !last) rom_addr <= {vram_data, row_q};
          if (phase == 3'd2 && !last) hold <= glyph;
          if (phase == 3'd7) begin
            phase <= '0;
            if (last) begin
              shift       <= '0;
              pixel_valid <= 1'b0;
              busy        <= 1'b0;
              line_done   <= 1'b1;
            end else begin
              shift <= hold;
              col   <= col + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_char_line_fetcher.sv
// tb_char_line_fetcher: scoreboard bench for char_line_fetcher with COLS=4
module tb_char_line_fetcher;
  localparam int COLS = 4;
  localparam int AW   = 11;

  logic          clk = 0;
  logic          reset_n = 0;
  logic          line_start = 0;
  logic [3:0]    row = 0;
  logic [AW-1:0] base_addr = 0;
  logic          cursor_en = 0;
  logic [7:0]    cursor_col = 0;
  logic          vram_re;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_data;
  logic [11:0]   rom_addr;
  logic [7:0]    rom_data;
  logic          pixel, pixel_valid, busy, line_done;

  logic [7:0] vram [0:2047];
  logic [7:0] rom  [0:4095];

  assign vram_data = vram[vram_addr];
  assign rom_data  = rom[rom_addr];

  char_line_fetcher #(.COLS(COLS), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .row(row),
    .base_addr(base_addr), .cursor_en(cursor_en), .cursor_col(cursor_col),
    .vram_re(vram_re), .vram_addr(vram_addr), .vram_data(vram_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .pixel(pixel),
    .pixel_valid(pixel_valid), .busy(busy), .line_done(line_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic          exp_pix [$];
  logic [AW-1:0] exp_vaddr [$];
  logic [11:0]   exp_raddr [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a read strobe, ROM address or pixel
  int cyc = 0, start_cyc = 0, run = 0, vre = 0;
  logic seen_first = 0, vre_prev = 0, prev_valid = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      vre_prev   = 0;
      prev_valid = 0;
    end else begin
      cyc++;
      if (line_start && !busy) begin
        start_cyc  = cyc + 1;
        run        = 0;
        vre        = 0;
        seen_first = 0;
      end
      if (vram_re) begin
        vre++;
        if (exp_vaddr.size() == 0) chk("vram_addr_unexpected", 1, 0);
        else chk("vram_addr", 32'(vram_addr), 32'(exp_vaddr.pop_front()));
      end
      if (vre_prev) begin
        if (exp_raddr.size() == 0) chk("rom_addr_unexpected", 1, 0);
        else chk("rom_addr", 32'(rom_addr), 32'(exp_raddr.pop_front()));
      end
      vre_prev = vram_re;
      if (pixel_valid) begin
        if (!seen_first) begin
          chk("first_pixel_latency", cyc - start_cyc, 3);
          seen_first = 1;
        end
        run++;
        if (exp_pix.size() == 0) chk("pixel_unexpected", 1, 0);
        else chk($sformatf("pixel%0d", run - 1), 32'(pixel), 32'(exp_pix.pop_front()));
      end
      if (line_done) begin
        chk("valid_run_len", run, COLS * 8);
        chk("vram_re_pulses", vre, COLS);
        chk("done_after_last_pixel", {prev_valid, pixel_valid}, 2'b10);
        chk("pixels_left", exp_pix.size(), 0);
      end
      prev_valid = pixel_valid;
    end
  end

  task automatic pulse(input logic [AW-1:0] b, input logic [3:0] r, input logic ce, input logic [7:0] cc);
    @(posedge clk); #1;
    line_start = 1; base_addr = b; row = r; cursor_en = ce; cursor_col = cc;
    @(posedge clk); #1;
    line_start = 0;
  endtask

  task automatic run_line(input logic [AW-1:0] b, input logic [3:0] r, input logic ce, input logic [7:0] cc);
    logic [AW-1:0] a;
    logic [7:0] g;
    for (int c = 0; c < COLS; c++) begin
      a = b + AW'(c);
      exp_vaddr.push_back(a);
      exp_raddr.push_back({vram[a], r});
      g = rom[{vram[a], r}];
      if (ce && cc == 8'(c)) g = ~g;
      for (int k = 7; k >= 0; k--) exp_pix.push_back(g[k]);
    end
    pulse(b, r, ce, cc);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!line_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("line_done_seen", 32'(line_done), 1);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'((i * 37) ^ (i >> 4));
    for (int i = 0; i < 2048; i++) vram[i] = 8'(i);
    vram[11'h100] = "A"; vram[11'h101] = "B"; vram[11'h102] = "C"; vram[11'h103] = "D";
    vram[11'h7FE] = 8'h21; vram[11'h7FF] = 8'h7E; vram[11'h000] = 8'h00; vram[11'h001] = 8'hFF;
    repeat (3) @(posedge clk); #1;
    chk("rst_pixel", 32'(pixel), 0);
    chk("rst_valid", 32'(pixel_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vram_re", 32'(vram_re), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    reset_n = 1;
    repeat (2) @(posedge clk);
    // hand-computed ROM addresses for 'A'..'D' at row 5
    chk("rom_addr_A_calc", 32'({vram[11'h100], 4'd5}), 32'h415);
    run_line(11'h100, 4'd5, 1'b0, 8'd0);
    wait_done();
    run_line(11'h100, 4'd5, 1'b1, 8'd2);
    wait_done();
    run_line(11'h100, 4'd3, 1'b1, 8'd9);
    wait_done();
    run_line(11'h7FE, 4'd9, 1'b1, 8'd0);
    wait_done();
    // line_start mid-line must be ignored
    run_line(11'h100, 4'd7, 1'b0, 8'd0);
    repeat (11) @(posedge clk);
    chk("busy_mid_line", 32'(busy), 1);
    pulse(11'h7FE, 4'd1, 1'b1, 8'd1);
    wait_done();
    chk("no_restart_busy", 32'(busy), 0);
    // asynchronous reset mid-SHIFT
    run_line(11'h100, 4'd2, 1'b0, 8'd0);
    repeat (12) @(posedge clk); #1;
    reset_n = 0;
    #1;
    chk("arst_pixel", 32'(pixel), 0);
    chk("arst_valid", 32'(pixel_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_vram_re", 32'(vram_re), 0);
    chk("arst_line_done", 32'(line_done), 0);
    exp_pix.delete(); exp_vaddr.delete(); exp_raddr.delete();
    repeat (2) @(posedge clk); #1;
    reset_n = 1;
    run_line(11'h101, 4'd15, 1'b1, 8'd3);
    wait_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
